// File: rtl/rv32i_types.sv
// Shared types for the out-of-order RV32I core: ROB entry, status and op type encodings,
// the commit half of the cdb bundle, and the small helpers that act on a single ROB entry.
package rv32i_types;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_MUL    = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_BRANCH = 3'd4,
    OP_JUMP   = 3'd5,
    OP_LUI    = 3'd6,
    OP_AUIPC  = 3'd7
  } types_t;

  typedef enum logic [1:0] {
    empty    = 2'd0,
    rob_wait = 2'd1,
    done     = 2'd2
  } status_t;

  typedef struct packed {
    logic        valid;
    status_t     status;
    types_t      op_type;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    rob_idx_t    rd_rob_idx;
  } rob_entry_t;

  typedef struct packed {
    logic        commit_valid;
    logic        regf_we;
    logic [31:0] commit_data;
    rob_idx_t    commit_rob_idx;
    logic [4:0]  commit_rd_addr;
  } cdb_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] data;
  } rob_lookup_t;

  // A result already held in the entry takes precedence over anything on the buses.
  function automatic rob_lookup_t rob_lookup(rob_entry_t e, logic alu_hit, logic [31:0] alu_d,
                                             logic mul_hit, logic [31:0] mul_d);
    rob_lookup_t r;
    r = '0;
    if (!e.valid) begin
      r = '0;
    end else if (e.status == done) begin
      r = '{ready: 1'b1, data: e.rd_data};
    end else if (mul_hit) begin
      r = '{ready: 1'b1, data: mul_d};
    end else if (alu_hit) begin
      r = '{ready: 1'b1, data: alu_d};
    end else begin
      r = '{ready: 1'b0, data: e.rd_data};
    end
    return r;
  endfunction

  function automatic cdb_t rob_commit(rob_entry_t e);
    cdb_t c;
    c = '0;
    if (e.valid && (e.status == done)) begin
      c.commit_valid   = 1'b1;
      c.regf_we        = (e.rd_addr != 5'd0);
      c.commit_data    = e.rd_data;
      c.commit_rob_idx = e.rd_rob_idx;
      c.commit_rd_addr = e.rd_addr;
    end else begin
      c = '0;
    end
    return c;
  endfunction

endpackage

// File: rtl/reorder_buffer_checker.sv
// Protocol checks for the reorder buffer writeback buses.
module reorder_buffer_checker
  import rv32i_types::*;
(
  input logic     clk,
  input logic     rst_n,
  input logic     alu_valid,
  input rob_idx_t alu_rob_idx,
  input logic     mul_valid,
  input rob_idx_t mul_rob_idx
);

  // Both writeback buses must never target the same entry in one cycle.
  a_no_dual_wb: assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_valid && mul_valid && (alu_rob_idx == mul_rob_idx)));

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order ALU/MUL completion,
// in-order single retire per cycle, and two dispatch operand lookups with bus bypass.
module reorder_buffer
  import rv32i_types::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [2:0]       alloc_op_type,
  input  logic [4:0]       alloc_rd_addr,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_rob_idx,
  input  logic             alu_valid,
  input  logic [31:0]      alu_data,
  input  logic [IDX_W-1:0] alu_rob_idx,
  input  logic             mul_valid,
  input  logic [31:0]      mul_data,
  input  logic [IDX_W-1:0] mul_rob_idx,
  input  logic [IDX_W-1:0] rs1_rob_idx,
  output logic             rs1_rob_ready,
  output logic [31:0]      rs1_rob_data,
  input  logic [IDX_W-1:0] rs2_rob_idx,
  output logic             rs2_rob_ready,
  output logic [31:0]      rs2_rob_data,
  output logic             commit_valid,
  output logic             regf_we,
  output logic [31:0]      commit_data,
  output logic [IDX_W-1:0] commit_rob_idx,
  output logic [4:0]       commit_rd_addr
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

  rob_entry_t       r_entries [DEPTH];
  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [IDX_W:0]   r_count;

  logic        w_alloc_fire;
  logic        w_alu_hit;
  logic        w_mul_hit;
  cdb_t        w_cdb;
  rob_lookup_t w_rs1;
  rob_lookup_t w_rs2;

  // Space is judged on registered count only, so a same-cycle retire never frees a slot early.
  assign alloc_ready   = (r_count != FULL_CNT);
  assign alloc_rob_idx = r_tail;
  assign w_alloc_fire  = alloc_valid && alloc_ready;

  assign w_alu_hit = alu_valid && r_entries[alu_rob_idx].valid && (r_entries[alu_rob_idx].status == rob_wait);
  assign w_mul_hit = mul_valid && r_entries[mul_rob_idx].valid && (r_entries[mul_rob_idx].status == rob_wait);

  assign w_cdb          = rob_commit(r_entries[r_head]);
  assign commit_valid   = w_cdb.commit_valid;
  assign regf_we        = w_cdb.regf_we;
  assign commit_data    = w_cdb.commit_data;
  assign commit_rob_idx = w_cdb.commit_rob_idx;
  assign commit_rd_addr = w_cdb.commit_rd_addr;

  assign w_rs1 = rob_lookup(r_entries[rs1_rob_idx],
                            alu_valid && (alu_rob_idx == rs1_rob_idx), alu_data,
                            mul_valid && (mul_rob_idx == rs1_rob_idx), mul_data);
  assign w_rs2 = rob_lookup(r_entries[rs2_rob_idx],
                            alu_valid && (alu_rob_idx == rs2_rob_idx), alu_data,
                            mul_valid && (mul_rob_idx == rs2_rob_idx), mul_data);
  assign rs1_rob_ready = w_rs1.ready;
  assign rs1_rob_data  = w_rs1.data;
  assign rs2_rob_ready = w_rs2.ready;
  assign rs2_rob_data  = w_rs2.data;

  // Entry array and pointers; flush clears like reset and discards every other same-cycle update.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alu_hit) begin
        r_entries[alu_rob_idx].status  <= done;
        r_entries[alu_rob_idx].rd_data <= alu_data;
      end
      if (w_mul_hit) begin
        r_entries[mul_rob_idx].status  <= done;
        r_entries[mul_rob_idx].rd_data <= mul_data;
      end
      if (w_alloc_fire) begin
        r_entries[r_tail] <= '{valid: 1'b1, status: rob_wait, op_type: types_t'(alloc_op_type),
                               rd_addr: alloc_rd_addr, rd_data: 32'd0,
                               rd_rob_idx: ROB_IDX_W'(r_tail)};
        r_tail <= r_tail + IDX_W'(1);
      end
      if (w_cdb.commit_valid) begin
        r_entries[r_head].valid  <= 1'b0;
        r_entries[r_head].status <= empty;
        r_head <= r_head + IDX_W'(1);
      end
      r_count <= r_count + (IDX_W + 1)'(w_alloc_fire) - (IDX_W + 1)'(w_cdb.commit_valid);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based program-order model.
module tb_reorder_buffer;

  logic        clk;
  logic        rst_n, flush, alloc_valid;
  logic [2:0]  alloc_op_type;
  logic [4:0]  alloc_rd_addr;
  logic        alloc_ready;
  logic [4:0]  alloc_rob_idx;
  logic        alu_valid, mul_valid;
  logic [31:0] alu_data, mul_data;
  logic [4:0]  alu_rob_idx, mul_rob_idx;
  logic [4:0]  rs1_rob_idx, rs2_rob_idx;
  logic        rs1_rob_ready, rs2_rob_ready;
  logic [31:0] rs1_rob_data, rs2_rob_data;
  logic        commit_valid, regf_we;
  logic [31:0] commit_data;
  logic [4:0]  commit_rob_idx, commit_rd_addr;

  int n_cmp = 0;
  int n_bad = 0;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_op_type(alloc_op_type), .alloc_rd_addr(alloc_rd_addr),
    .alloc_ready(alloc_ready), .alloc_rob_idx(alloc_rob_idx),
    .alu_valid(alu_valid), .alu_data(alu_data), .alu_rob_idx(alu_rob_idx),
    .mul_valid(mul_valid), .mul_data(mul_data), .mul_rob_idx(mul_rob_idx),
    .rs1_rob_idx(rs1_rob_idx), .rs1_rob_ready(rs1_rob_ready), .rs1_rob_data(rs1_rob_data),
    .rs2_rob_idx(rs2_rob_idx), .rs2_rob_ready(rs2_rob_ready), .rs2_rob_data(rs2_rob_data),
    .commit_valid(commit_valid), .regf_we(regf_we), .commit_data(commit_data),
    .commit_rob_idx(commit_rob_idx), .commit_rd_addr(commit_rd_addr)
  );

  reorder_buffer_checker chk_i (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rob_idx(alu_rob_idx),
    .mul_valid(mul_valid), .mul_rob_idx(mul_rob_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: entries live in program order in a queue of ROB indices.
  bit          m_valid [32];
  bit          m_done  [32];
  logic [31:0] m_data  [32];
  logic [4:0]  m_rd    [32];
  int          order[$];
  int          m_tail;
  int          pend[$];

  task automatic model_update();
    bit cfire, afire, wa, wm;
    if (!rst_n || flush) begin
      for (int i = 0; i < 32; i++) begin
        m_valid[i] = 1'b0; m_done[i] = 1'b0; m_data[i] = 32'd0; m_rd[i] = 5'd0;
      end
      order.delete();
      m_tail = 0;
    end else begin
      cfire = (order.size() > 0) && m_done[order[0]];
      afire = alloc_valid && (order.size() < 32);
      wa = alu_valid && m_valid[alu_rob_idx] && !m_done[alu_rob_idx];
      wm = mul_valid && m_valid[mul_rob_idx] && !m_done[mul_rob_idx];
      if (wa) begin m_done[alu_rob_idx] = 1'b1; m_data[alu_rob_idx] = alu_data; end
      if (wm) begin m_done[mul_rob_idx] = 1'b1; m_data[mul_rob_idx] = mul_data; end
      if (cfire) begin
        m_valid[order[0]] = 1'b0; m_done[order[0]] = 1'b0; m_data[order[0]] = 32'd0;
        void'(order.pop_front());
      end
      if (afire) begin
        m_valid[m_tail] = 1'b1; m_done[m_tail] = 1'b0; m_data[m_tail] = 32'd0;
        m_rd[m_tail] = alloc_rd_addr;
        order.push_back(m_tail);
        m_tail = (m_tail + 1) % 32;
      end
    end
  endtask

  task automatic model_lookup(input int idx, output bit r, output logic [31:0] d);
    r = 1'b0; d = 32'd0;
    if (m_valid[idx]) begin
      if (m_done[idx]) begin r = 1'b1; d = m_data[idx]; end
      else if (mul_valid && (int'(mul_rob_idx) == idx)) begin r = 1'b1; d = mul_data; end
      else if (alu_valid && (int'(alu_rob_idx) == idx)) begin r = 1'b1; d = alu_data; end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit ecv, r1, r2;
    int h;
    logic [31:0] d1, d2;
    ecv = (order.size() > 0) && m_done[order[0]];
    h = ecv ? order[0] : 0;
    chk("rnd_alloc_ready", 32'(alloc_ready), 32'(order.size() < 32));
    chk("rnd_alloc_idx", 32'(alloc_rob_idx), 32'(m_tail));
    chk("rnd_commit_valid", 32'(commit_valid), 32'(ecv));
    chk("rnd_regf_we", 32'(regf_we), 32'(ecv && (m_rd[h] != 5'd0)));
    chk("rnd_commit_data", commit_data, ecv ? m_data[h] : 32'd0);
    chk("rnd_commit_idx", 32'(commit_rob_idx), ecv ? 32'(h) : 32'd0);
    chk("rnd_commit_rd", 32'(commit_rd_addr), ecv ? 32'(m_rd[h]) : 32'd0);
    model_lookup(int'(rs1_rob_idx), r1, d1);
    model_lookup(int'(rs2_rob_idx), r2, d2);
    chk("rnd_rs1_ready", 32'(rs1_rob_ready), 32'(r1));
    chk("rnd_rs1_data", rs1_rob_data, d1);
    chk("rnd_rs2_ready", 32'(rs2_rob_ready), 32'(r2));
    chk("rnd_rs2_data", rs2_rob_data, d2);
  endtask

  task automatic clr_in();
    rst_n = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_op_type = 3'd0; alloc_rd_addr = 5'd0;
    alu_valid = 1'b0; alu_data = 32'd0; alu_rob_idx = 5'd0;
    mul_valid = 1'b0; mul_data = 32'd0; mul_rob_idx = 5'd0;
    rs1_rob_idx = 5'd31; rs2_rob_idx = 5'd31;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clr_in(); rst_n = 1'b0; tick(); clr_in();
  endtask

  task automatic chk_commit(input string n, input logic cv, input logic we, input logic [31:0] cd,
                            input logic [4:0] ci, input logic [4:0] crd);
    chk({n, "_cv"}, 32'(commit_valid), 32'(cv));
    chk({n, "_we"}, 32'(regf_we), 32'(we));
    chk({n, "_cd"}, commit_data, cd);
    chk({n, "_ci"}, 32'(commit_rob_idx), 32'(ci));
    chk({n, "_crd"}, 32'(commit_rd_addr), 32'(crd));
  endtask

  typedef struct packed {
    logic av; logic [4:0] ard; logic [2:0] aop;
    logic aluv; logic [4:0] alui; logic [31:0] alud;
    logic mulv; logic [4:0] muli; logic [31:0] muld;
    logic [4:0] rs1; logic [4:0] rs2;
    logic [4:0] e_aidx;
    logic e_cv; logic e_we; logic [31:0] e_cd; logic [4:0] e_ci; logic [4:0] e_crd;
    logic e_r1; logic [31:0] e_d1; logic e_r2; logic [31:0] e_d2;
  } vec_t;

  vec_t tbl [23];

  initial begin
    // av ard aop | alu v,i,d | mul v,i,d | rs1 rs2 | aidx | cv we cd ci crd | r1 d1 r2 d2
    tbl[0]  = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd0,5'd0,   5'd0, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};
    tbl[1]  = '{1'b1,5'd1,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd0, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};
    tbl[2]  = '{1'b1,5'd2,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd1, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};
    tbl[3]  = '{1'b1,5'd3,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd2, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};
    tbl[4]  = '{1'b0,5'd0,3'd0, 1'b1,5'd1,32'h11, 1'b0,5'd0,32'h0,  5'd1,5'd0,   5'd3, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b1,32'h11,1'b0,32'h0};
    tbl[5]  = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b1,5'd0,32'h22, 5'd1,5'd0,   5'd3, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b1,32'h11,1'b1,32'h22};
    tbl[6]  = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd2,5'd0,   5'd3, 1'b1,1'b1,32'h22,5'd0,5'd1, 1'b0,32'h0,1'b1,32'h22};
    tbl[7]  = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd2,5'd0,   5'd3, 1'b1,1'b1,32'h11,5'd1,5'd2, 1'b0,32'h0,1'b0,32'h0};
    tbl[8]  = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd3, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};
    tbl[9]  = '{1'b1,5'd4,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd3, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};
    tbl[10] = '{1'b1,5'd5,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd4, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};
    tbl[11] = '{1'b1,5'd6,3'd1, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd5, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};
    tbl[12] = '{1'b0,5'd0,3'd0, 1'b1,5'd4,32'hA,  1'b1,5'd5,32'hB,  5'd4,5'd5,   5'd6, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b1,32'hA,1'b1,32'hB};
    tbl[13] = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd4,5'd5,   5'd6, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b1,32'hA,1'b1,32'hB};
    tbl[14] = '{1'b0,5'd0,3'd0, 1'b1,5'd2,32'h33, 1'b1,5'd3,32'h44, 5'd31,5'd31, 5'd6, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};
    tbl[15] = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd6, 1'b1,1'b1,32'h33,5'd2,5'd3, 1'b0,32'h0,1'b0,32'h0};
    tbl[16] = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd6, 1'b1,1'b1,32'h44,5'd3,5'd4, 1'b0,32'h0,1'b0,32'h0};
    tbl[17] = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd6, 1'b1,1'b1,32'hA,5'd4,5'd5,  1'b0,32'h0,1'b0,32'h0};
    tbl[18] = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd6, 1'b1,1'b1,32'hB,5'd5,5'd6,  1'b0,32'h0,1'b0,32'h0};
    tbl[19] = '{1'b1,5'd0,3'd3, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd6, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};
    tbl[20] = '{1'b0,5'd0,3'd0, 1'b1,5'd6,32'h55, 1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd7, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};
    tbl[21] = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd7, 1'b1,1'b0,32'h55,5'd6,5'd0, 1'b0,32'h0,1'b0,32'h0};
    tbl[22] = '{1'b0,5'd0,3'd0, 1'b0,5'd0,32'h0,  1'b0,5'd0,32'h0,  5'd31,5'd31, 5'd7, 1'b0,1'b0,32'h0,5'd0,5'd0,  1'b0,32'h0,1'b0,32'h0};

    do_reset();
    for (int k = 0; k < 23; k++) begin
      clr_in();
      alloc_valid = tbl[k].av; alloc_rd_addr = tbl[k].ard; alloc_op_type = tbl[k].aop;
      alu_valid = tbl[k].aluv; alu_rob_idx = tbl[k].alui; alu_data = tbl[k].alud;
      mul_valid = tbl[k].mulv; mul_rob_idx = tbl[k].muli; mul_data = tbl[k].muld;
      rs1_rob_idx = tbl[k].rs1; rs2_rob_idx = tbl[k].rs2;
      #1;
      chk($sformatf("tbl%0d_ready", k), 32'(alloc_ready), 32'd1);
      chk($sformatf("tbl%0d_aidx", k), 32'(alloc_rob_idx), 32'(tbl[k].e_aidx));
      chk_commit($sformatf("tbl%0d", k), tbl[k].e_cv, tbl[k].e_we, tbl[k].e_cd, tbl[k].e_ci, tbl[k].e_crd);
      chk($sformatf("tbl%0d_r1", k), 32'(rs1_rob_ready), 32'(tbl[k].e_r1));
      chk($sformatf("tbl%0d_d1", k), rs1_rob_data, tbl[k].e_d1);
      chk($sformatf("tbl%0d_r2", k), 32'(rs2_rob_ready), 32'(tbl[k].e_r2));
      chk($sformatf("tbl%0d_d2", k), rs2_rob_data, tbl[k].e_d2);
      tick();
    end

    // Fill all 32 entries, then show full back-pressure, retire, and wrap to index 0.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      clr_in(); alloc_valid = 1'b1; alloc_rd_addr = 5'(i);
      #1;
      chk("full_fill_ready", 32'(alloc_ready), 32'd1);
      chk("full_fill_idx", 32'(alloc_rob_idx), 32'(i));
      tick();
    end
    clr_in(); alloc_valid = 1'b1; alloc_rd_addr = 5'd9;
    #1;
    chk("full_33rd_ready", 32'(alloc_ready), 32'd0);
    chk("full_33rd_idx", 32'(alloc_rob_idx), 32'd0);
    tick();
    clr_in(); alu_valid = 1'b1; alu_rob_idx = 5'd0; alu_data = 32'h99;
    #1;
    chk("full_hold_ready", 32'(alloc_ready), 32'd0);
    chk("full_hold_idx", 32'(alloc_rob_idx), 32'd0);
    tick();
    clr_in(); alloc_valid = 1'b1; alloc_rd_addr = 5'd9;
    #1;
    chk_commit("full_commit", 1'b1, 1'b0, 32'h99, 5'd0, 5'd0);
    chk("full_commit_ready", 32'(alloc_ready), 32'd0);
    tick();
    clr_in(); alloc_valid = 1'b1; alloc_rd_addr = 5'd7;
    #1;
    chk("full_freed_ready", 32'(alloc_ready), 32'd1);
    chk("full_wrap_idx", 32'(alloc_rob_idx), 32'd0);
    tick();
    clr_in();
    #1;
    chk("full_after_idx", 32'(alloc_rob_idx), 32'd1);
    chk("full_after_ready", 32'(alloc_ready), 32'd0);
    tick();

    // Flush with a completed head and a pending allocation.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      clr_in(); alloc_valid = 1'b1; alloc_rd_addr = 5'(i + 1); tick();
    end
    clr_in(); alu_valid = 1'b1; alu_rob_idx = 5'd2; alu_data = 32'h2;
    mul_valid = 1'b1; mul_rob_idx = 5'd3; mul_data = 32'h3; tick();
    clr_in(); alu_valid = 1'b1; alu_rob_idx = 5'd0; alu_data = 32'h1; tick();
    clr_in(); flush = 1'b1; alloc_valid = 1'b1; alloc_rd_addr = 5'd8;
    alu_valid = 1'b1; alu_rob_idx = 5'd4; alu_data = 32'h4;
    #1;
    chk_commit("flush_cyc", 1'b1, 1'b1, 32'h1, 5'd0, 5'd1);
    tick();
    clr_in(); rs1_rob_idx = 5'd2; rs2_rob_idx = 5'd0;
    #1;
    chk("flush_ready", 32'(alloc_ready), 32'd1);
    chk("flush_idx", 32'(alloc_rob_idx), 32'd0);
    chk_commit("flush_after", 1'b0, 1'b0, 32'h0, 5'd0, 5'd0);
    chk("flush_rs1_ready", 32'(rs1_rob_ready), 32'd0);
    chk("flush_rs1_data", rs1_rob_data, 32'd0);
    chk("flush_rs2_ready", 32'(rs2_rob_ready), 32'd0);
    tick();

    // Reset mid-stream with ten outstanding entries; a later stale writeback must be ignored.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      clr_in(); alloc_valid = 1'b1; alloc_rd_addr = 5'(i + 1); tick();
    end
    clr_in(); alu_valid = 1'b1; alu_rob_idx = 5'd0; alu_data = 32'h50;
    mul_valid = 1'b1; mul_rob_idx = 5'd6; mul_data = 32'h60; tick();
    clr_in(); rst_n = 1'b0; alloc_valid = 1'b1; alu_valid = 1'b1; alu_rob_idx = 5'd3; alu_data = 32'h77;
    #1;
    chk_commit("rst_pre", 1'b1, 1'b1, 32'h50, 5'd0, 5'd1);
    tick();
    clr_in(); alu_valid = 1'b1; alu_rob_idx = 5'd3; alu_data = 32'h78;
    rs1_rob_idx = 5'd3; rs2_rob_idx = 5'd6;
    #1;
    chk("rst_ready", 32'(alloc_ready), 32'd1);
    chk("rst_idx", 32'(alloc_rob_idx), 32'd0);
    chk_commit("rst_after", 1'b0, 1'b0, 32'h0, 5'd0, 5'd0);
    chk("rst_rs1_ready", 32'(rs1_rob_ready), 32'd0);
    chk("rst_rs1_data", rs1_rob_data, 32'd0);
    chk("rst_rs2_ready", 32'(rs2_rob_ready), 32'd0);
    tick();
    clr_in(); rs1_rob_idx = 5'd3;
    #1;
    chk("rst_stale_ready", 32'(rs1_rob_ready), 32'd0);
    chk("rst_stale_idx", 32'(alloc_rob_idx), 32'd0);
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      clr_in();
      if ($urandom_range(0, 255) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 63) == 0) flush = 1'b1;
      alloc_valid = ($urandom_range(0, 2) != 0);
      alloc_rd_addr = 5'($urandom);
      alloc_op_type = 3'($urandom);
      pend.delete();
      foreach (order[j]) if (!m_done[order[j]]) pend.push_back(order[j]);
      if ($urandom_range(0, 1) == 1) begin
        alu_valid = 1'b1; alu_data = $urandom;
        alu_rob_idx = (pend.size() > 0 && $urandom_range(0, 3) != 0) ?
                      5'(pend[$urandom_range(0, pend.size() - 1)]) : 5'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        mul_valid = 1'b1; mul_data = $urandom;
        mul_rob_idx = (pend.size() > 0 && $urandom_range(0, 3) != 0) ?
                      5'(pend[$urandom_range(0, pend.size() - 1)]) : 5'($urandom);
      end
      if (alu_valid && mul_valid && (alu_rob_idx == mul_rob_idx)) mul_valid = 1'b0;
      rs1_rob_idx = ($urandom_range(0, 1) == 1) ? alu_rob_idx : 5'($urandom);
      rs2_rob_idx = ($urandom_range(0, 1) == 1) ? mul_rob_idx : 5'($urandom);
      #1;
      check_model();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer for the out-of-order RV32I core. It receives an in-order allocation from dispatch and out-of-order completions from the ALU and MUL writeback buses.
- It retires completed entries strictly in program order, one per cycle, driving the commit half of the cdb bundle to the register file and rename logic.
- It also answers operand-readiness lookups for dispatch by ROB index.

Parameters:
- DEPTH, 32, number of entries; power of two.
- IDX_W, 5, index width; equals log2(DEPTH). Matches the 5-bit rob_idx fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- flush  in  1  discard all entries (branch recovery)
- alloc_valid  in  1  dispatch requests an entry
- alloc_op_type  in  3  types_t of the instruction
- alloc_rd_addr  in  5  architectural destination
- alloc_ready  out  1  an entry can be accepted this cycle
- alloc_rob_idx  out  IDX_W  index given to the request (current tail)
- alu_valid  in  1  ALU writeback valid
- alu_data  in  32  ALU result
- alu_rob_idx  in  IDX_W  ALU target entry
- mul_valid  in  1  MUL writeback valid
- mul_data  in  32  MUL result
- mul_rob_idx  in  IDX_W  MUL target entry
- rs1_rob_idx  in  IDX_W  lookup index 1
- rs1_rob_ready  out  1  entry 1 result available
- rs1_rob_data  out  32  entry 1 result
- rs2_rob_idx  in  IDX_W  lookup index 2
- rs2_rob_ready  out  1  entry 2 result available
- rs2_rob_data  out  32  entry 2 result
- commit_valid  out  1  head entry retires this cycle
- regf_we  out  1  commit writes the register file
- commit_data  out  32  retiring result
- commit_rob_idx  out  IDX_W  retiring entry index
- commit_rd_addr  out  5  retiring destination

Behaviour:
- State:
  - rob_entry_t array[DEPTH]
  - head, tail: IDX_W bits each; wrap naturally modulo DEPTH
  - count: IDX_W+1 bits
- Reset (rst_n=0 at a clk edge):
  - Every entry: valid=0, status=empty.
  - head=tail=count=0.
  - Resulting outputs: alloc_ready=1, alloc_rob_idx=0, commit_valid=0, regf_we=0, commit_data/commit_rob_idx/commit_rd_addr=0, rsX_rob_ready=0.
  - Reset overrides flush and all other inputs.
- Allocation:
  - alloc_ready = (count != DEPTH), computed from registered count only. A commit in the same cycle does not free space for that cycle's allocation.
  - alloc_rob_idx = tail.
  - On alloc_valid && alloc_ready, entry[tail] gets: valid=1, status=rob_wait, op_type, rd_addr, rd_data=0, rd_rob_idx=tail. Then tail+1.
  - alloc_valid while not ready is ignored; no state change.
- Writeback:
  - alu_valid sets entry[alu_rob_idx] to status=done with rd_data=alu_data, only if that entry is valid and in rob_wait. mul_valid does the same for the MUL fields.
  - ALU and MUL may target different entries in the same cycle; both update.
  - Writeback to an invalid or already-done entry is ignored.
  - Same index on both buses is illegal; it is flagged by an assertion, and MUL wins.
- Commit:
  - commit_valid = entry[head].valid && entry[head].status==done. This is combinational from registered state.
  - commit_data, commit_rob_idx, commit_rd_addr come from the head entry. All are 0 when commit_valid=0.
  - regf_we = commit_valid && (rd_addr != 0).
  - When commit_valid: entry[head].valid=0, status=empty, head+1. At most one retire per cycle.
  - Minimum latency writeback→commit is 1 cycle: a head entry written back in cycle N commits in cycle N+1.
- count update per cycle: count + alloc_fire − commit_fire. Simultaneous alloc and commit leaves count unchanged.
- Lookup (combinational):
  - rsX_rob_ready = 1 if entry[idx] is valid and done, or if alu_valid/mul_valid targets idx this cycle (bypass).
  - rsX_rob_data is the matching bus data for a bypass, else entry rd_data.
  - An invalid entry returns ready=0 and data=0.
- Flush (synchronous, when rst_n=1):
  - All entries invalid/empty; head=tail=count=0.
  - Alloc, writeback and commit in the flush cycle are discarded.
  - commit_valid is still driven combinationally in that cycle. The commit side must gate it with flush. No register update occurs for that commit.
- Wrap-around: head/tail overflow from DEPTH-1 to 0 with no special handling. Full is detected only by count, so head==tail is ambiguous without it.

Decomposition:
- rob_entry_t, status_t, types_t and the cdb struct live in rv32i_types.
- Add a package localparam ROB_DEPTH=32 and ROB_IDX_W=$clog2(ROB_DEPTH). The cdb and reservation-station index widths derive from these.
- Single module with no sub-module; the entry array is plain flops because lookups need two async reads plus the head read.

Test Plan:
- Reset, then allocate 3 entries (rd=1,2,3) → alloc_rob_idx 0,1,2. Write back idx1 (ALU, 0x11), then idx0 (MUL, 0x22) → commit idx0 (0x22, rd1) next cycle, idx1 (0x11, rd2) the cycle after; no commit of idx2.
- Allocate 32 entries → alloc_ready=0 on the 33rd request, tail unchanged. Complete head and commit → alloc_ready=1 the following cycle. Allocation lands at idx0 after wrap.
- Same-cycle ALU→idx4 (0xA) and MUL→idx5 (0xB) with rs1_rob_idx=4, rs2_rob_idx=5 → both lookups ready with 0xA/0xB in that cycle (bypass); entries done next cycle.
- Allocate a store-type entry with rd=0 and complete it → commit_valid=1, regf_we=0.
- Allocate 5, complete 2, assert flush with alloc_valid=1 → next cycle count=0, alloc_rob_idx=0, commit_valid=0, all lookups not ready.
- rst_n=0 asserted mid-stream with 10 entries outstanding → next cycle all outputs at reset values; a stale writeback to idx3 is ignored.
